grid_scan_driver: RTL and testbench
===================================

// Module: grid_scan_driver
// PURPOSE
//  Downstream consumer of the game-of-life core's 64-bit live grid (q).
//  Double-buffers each new generation and scans it row-by-row onto an 8x8 LED matrix.
//  Output is registered and multiplexed: one-hot row select plus column data.
//  A blanking gap between rows prevents ghosting; buffer swaps occur only at frame boundaries (tear-free).
// PARAMETERS
//  ROWS   8     matrix rows (grid width = ROWS*COLS)
//  COLS   8     matrix columns
//  DWELL  1000  cycles each row is lit; must be >= 1
//  BLANK  8     dark cycles before each row; 0 = no blanking state
// PORTS
//  clk         in   1   single system clock, all logic on rising edge
//  reset       in   1   synchronous, active-high
//  enable      in   1   scan enable; sampled in IDLE and at end of each row
//  grid_in     in   64  generation from game core; [63:56]=row0, bit63=row0/col0
//  grid_valid  in   1   1-cycle strobe: grid_in holds a new generation
//  frame_ack   out  1   1-cycle pulse, cycle after grid_valid was captured
//  row_sel     out  8   one-hot row drive, row_sel[r] = row r; 0 when dark
//  col_data    out  8   column data for lit row, col_data[7]=col0; 0 when dark
//  frame_done  out  1   1-cycle pulse at end of row ROWS-1 dwell
// BEHAVIOUR
//  Reset: state=IDLE, row=0, timer=0, shadow=0, frame_buf=0, pending=0.
//   All outputs are 0. Reset mid-operation returns to this state on the next edge.
//  Capture: on an edge with grid_valid=1, shadow<=grid_in, pending<=1, frame_ack<=1.
//   Any state, including IDLE. A second strobe before the swap overwrites shadow (latest wins).
//   Each strobe produces its own ack.
//  Swap (frame boundary): frame_buf<=shadow, pending<=0 when pending=1.
//   Boundaries are: leaving IDLE, and the end of row ROWS-1.
//   If grid_valid=1 on the boundary edge, frame_buf takes grid_in directly (bypass).
//   In that case pending ends 0.
//  FSM (scan_state_t):
//   IDLE:  outputs dark. enable=1 -> swap, row=0, then BLANK (or SHOW if BLANK=0).
//   BLANK: outputs dark for exactly BLANK cycles -> SHOW.
//   SHOW:  row_sel=1<<row; col_data=frame_buf[63-8*row -: 8] for exactly DWELL cycles.
//    On the last SHOW cycle of row ROWS-1: frame_done pulses, row wraps to 0, swap.
//    Otherwise row++.
//    Then enable=1 -> BLANK/SHOW; enable=0 -> IDLE with row=0.
//  enable drop mid-row: the current row finishes its full dwell, then goes IDLE.
//   A dropped frame has no frame_done unless the row was ROWS-1.
//  Latency: first lit cycle is 1+BLANK cycles after the edge that samples enable=1.
//  Frame period = ROWS*(BLANK+DWELL) cycles.
//  Timer: down-counter, width $clog2(max(DWELL,BLANK)+1); loads N-1 and expires at 0.
//   No wrap beyond its load.
//  frame_ack/frame_done are never wider than 1 cycle.
//   row_sel never has more than one bit set.
// STRUCTURE
//  game_pkg: GRID_W=64, ROWS, COLS, scan_state_t {IDLE, BLANK, SHOW}.
//  Sub-module scan_timer: load value, load strobe, expire flag.
//  Row decode and column slicing stay inline.
// TESTING (bench: DWELL=4, BLANK=2)
//  1 Reset held, enable=0 for 20 cycles -> row_sel=00, col_data=00, frame_ack=frame_done=0 throughout.
//  2 grid 64'h8040201008040201 strobed, enable=1 -> frame_ack next cycle.
//    Row r shows row_sel=1<<r, col_data=8'h80>>r for 4 cycles after 2 dark cycles.
//    frame_done pulses once per 48 cycles.
//  3 Mid-frame (row 3) strobe of 64'hFFFF_FFFF_FFFF_FFFF -> rows 3..7 still diagonal.
//    After frame_done, every row col_data=8'hFF.
//  4 Strobes 64'hAAAA.. then 64'h5555.. in same frame -> two frame_ack pulses.
//    Next frame all rows 8'h55.
//  5 enable=0 during row 3 dwell -> row 3 completes its 4 cycles, then dark, no frame_done.
//    Re-enable restarts at row 0 after 2 dark cycles.
//  6 reset pulse during row 5 SHOW -> outputs 0 next cycle.
//    On re-enable all rows show col_data=8'h00 (buffers cleared).

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and sizing for the life-grid display path.
package game_pkg;

    localparam int unsigned ROWS   = 8;
    localparam int unsigned COLS   = 8;
    localparam int unsigned GRID_W = ROWS * COLS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

    // One timer serves both the dwell and blanking phases, so it is sized for the longer one.
    function automatic int unsigned tmr_width(input int unsigned dwell, input int unsigned blank);
        return $clog2(((dwell > blank) ? dwell : blank) + 1);
    endfunction

endpackage

// File: rtl/grid_scan_driver_timer.sv
// Loadable down-counter that stops at zero; expired is high while the count is zero.
module scan_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/grid_scan_driver.sv
// Double-buffered row scanner: latches life generations and multiplexes them onto an LED matrix.
module grid_scan_driver #(
    parameter int unsigned ROWS  = game_pkg::ROWS,
    parameter int unsigned COLS  = game_pkg::COLS,
    parameter int unsigned DWELL = 1000,
    parameter int unsigned BLANK = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] grid_in,
    input  logic                 grid_valid,
    output logic                 frame_ack,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_data,
    output logic                 frame_done
);

    import game_pkg::*;

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned TW = tmr_width(DWELL, BLANK);
    localparam logic [TW-1:0] DWELL_LD = TW'(DWELL - 1);
    localparam logic [TW-1:0] BLANK_LD = TW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    scan_state_t            state, state_next;
    logic [RW-1:0]          row, row_next;
    logic [ROWS*COLS-1:0]   shadow, frame_buf;
    logic                   pending;
    logic                   tmr_load, tmr_expired, swap, done_next;
    logic [TW-1:0]          tmr_val;
    logic [ROWS-1:0]        lit_rows;
    logic [COLS-1:0]        lit_cols;

    scan_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_comb begin
        lit_rows = '0;
        lit_cols = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (RW'(r) == row) begin
                lit_rows[r] = 1'b1;
                lit_cols    = frame_buf[ROWS*COLS-1-COLS*r -: COLS];
            end
        end
    end

    always_comb begin
        state_next = state;
        row_next   = row;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        swap       = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    swap     = 1'b1;
                    row_next = '0;
                    tmr_load = 1'b1;
                    if (BLANK > 0) begin
                        state_next = ST_BLANK;
                        tmr_val    = BLANK_LD;
                    end else begin
                        state_next = ST_SHOW;
                        tmr_val    = DWELL_LD;
                    end
                end
            end
            ST_BLANK: begin
                if (tmr_expired) begin
                    state_next = ST_SHOW;
                    tmr_load   = 1'b1;
                    tmr_val    = DWELL_LD;
                end
            end
            ST_SHOW: begin
                if (tmr_expired) begin
                    if (row == LAST_ROW) begin
                        done_next = 1'b1;
                        swap      = 1'b1;
                        row_next  = '0;
                    end else begin
                        row_next = row + 1'b1;
                    end
                    if (!enable) begin
                        state_next = ST_IDLE;
                        row_next   = '0;
                    end else if (BLANK > 0) begin
                        state_next = ST_BLANK;
                        tmr_load   = 1'b1;
                        tmr_val    = BLANK_LD;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = DWELL_LD;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            row        <= '0;
            shadow     <= '0;
            frame_buf  <= '0;
            pending    <= 1'b0;
            frame_ack  <= 1'b0;
            frame_done <= 1'b0;
            row_sel    <= '0;
            col_data   <= '0;
        end else begin
            state      <= state_next;
            row        <= row_next;
            frame_ack  <= grid_valid;
            frame_done <= done_next;
            row_sel    <= (state == ST_SHOW) ? lit_rows : '0;
            col_data   <= (state == ST_SHOW) ? lit_cols : '0;
            if (grid_valid) begin
                shadow <= grid_in;
            end
            // A strobe on the boundary edge bypasses the shadow so it is not held a whole frame.
            if (swap) begin
                if (grid_valid) begin
                    frame_buf <= grid_in;
                end else if (pending) begin
                    frame_buf <= shadow;
                end
                pending <= 1'b0;
            end else if (grid_valid) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grid_scan_driver.sv
// Self-checking bench for grid_scan_driver: per-cycle position-based model plus directed sequences.
module tb_grid_scan_driver;

    localparam int unsigned DW    = 4;
    localparam int unsigned BL    = 2;
    localparam int unsigned SLOT  = DW + BL;
    localparam int unsigned FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        grid_valid = 1'b0;
    logic [63:0] grid_in = '0;
    logic        frame_ack, frame_done;
    logic [7:0]  row_sel, col_data;

    always #5 clk = ~clk;

    grid_scan_driver #(.ROWS(8), .COLS(8), .DWELL(DW), .BLANK(BL)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .grid_in    (grid_in),
        .grid_valid (grid_valid),
        .frame_ack  (frame_ack),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_done (frame_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: a running flag plus a position within the frame (0..FRAME-1).
    bit          m_run = 1'b0;
    int          m_pos = 0;
    bit          m_pend = 1'b0;
    logic [63:0] m_shadow = '0, m_fbuf = '0;
    logic [7:0]  e_row = '0, e_col = '0;
    logic        e_ack = 1'b0, e_done = 1'b0;

    always @(posedge clk) begin
        bit swap;
        swap = 1'b0;
        if (reset) begin
            m_run = 0; m_pos = 0; m_pend = 0; m_shadow = '0; m_fbuf = '0;
            e_row = '0; e_col = '0; e_ack = 0; e_done = 0;
        end else begin
            e_ack = grid_valid;
            if (m_run && (m_pos % SLOT) >= BL) begin
                e_row = 8'(1 << (m_pos / SLOT));
                e_col = 8'(m_fbuf >> (8 * (7 - m_pos / SLOT)));
            end else begin
                e_row = '0;
                e_col = '0;
            end
            e_done = m_run && (m_pos == FRAME - 1);
            if (!m_run) begin
                if (enable) begin
                    m_run = 1; m_pos = 0; swap = 1;
                end
            end else if ((m_pos % SLOT) == SLOT - 1) begin
                if (m_pos == FRAME - 1) swap = 1;
                m_pos = (m_pos + 1) % FRAME;
                if (!enable) begin
                    m_run = 0; m_pos = 0;
                end
            end else begin
                m_pos++;
            end
            if (swap) begin
                m_fbuf = grid_valid ? grid_in : (m_pend ? m_shadow : m_fbuf);
                m_pend = 0;
            end else if (grid_valid) begin
                m_pend = 1;
            end
            if (grid_valid) m_shadow = grid_in;
        end
    end

    always @(negedge clk) begin
        check("model_row_sel", 64'(row_sel), 64'(e_row));
        check("model_col_data", 64'(col_data), 64'(e_col));
        check("model_frame_ack", 64'(frame_ack), 64'(e_ack));
        check("model_frame_done", 64'(frame_done), 64'(e_done));
        check("row_sel_onehot0", 64'($onehot0(row_sel)), 64'(1));
    end

    task automatic wait_row(input int r, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (row_sel == 8'(1 << r)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("wait_row");
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (frame_done) begin
                n = i;
                break;
            end
        end
        if (n == 0) timeout("wait_done");
    endtask

    typedef struct {
        logic [63:0] grid;
        int          row;
        logic [7:0]  col;
    } vec_t;

    vec_t vt[6];

    initial begin
        bit ok;
        int n, cnt;

        vt[0] = '{64'h0123456789ABCDEF, 0, 8'h01};
        vt[1] = '{64'h0123456789ABCDEF, 7, 8'hEF};
        vt[2] = '{64'h0123456789ABCDEF, 4, 8'h89};
        vt[3] = '{64'h8040201008040201, 3, 8'h10};
        vt[4] = '{64'hFFFF0000FFFF0000, 2, 8'h00};
        vt[5] = '{64'hDEADBEEFCAFEF00D, 5, 8'hFE};

        // 1: reset held, everything dark
        repeat (20) begin
            @(negedge clk);
            check("rst_row_sel", 64'(row_sel), 64'h0);
            check("rst_col_data", 64'(col_data), 64'h0);
            check("rst_ack_done", 64'({frame_ack, frame_done}), 64'h0);
        end
        reset = 0;
        repeat (3) @(negedge clk);

        // 2: diagonal pattern, ack, latency, frame period
        grid_in = 64'h8040201008040201; grid_valid = 1; enable = 1;
        @(negedge clk);
        grid_valid = 0;
        check("t2_ack", 64'(frame_ack), 64'h1);
        check("t2_dark0", 64'(row_sel), 64'h0);
        @(negedge clk); check("t2_dark1", 64'(row_sel), 64'h0);
        @(negedge clk); check("t2_dark2", 64'(row_sel), 64'h0);
        @(negedge clk);
        check("t2_first_row", 64'(row_sel), 64'h01);
        check("t2_first_col", 64'(col_data), 64'h80);
        wait_done(n);
        wait_done(n);
        check("t2_period", 64'(n), 64'(FRAME));

        // 3: all-ones strobed during row 3 takes effect next frame only
        wait_row(3, ok);
        grid_in = '1; grid_valid = 1;
        @(negedge clk);
        grid_valid = 0;
        for (int r = 4; r < 8; r++) begin
            wait_row(r, ok);
            check("t3_old_frame", 64'(col_data), 64'(8'h80 >> r));
        end
        wait_done(n);
        for (int r = 0; r < 8; r++) begin
            wait_row(r, ok);
            check("t3_new_frame", 64'(col_data), 64'hFF);
        end

        // 4: latest of two strobes wins, each acked
        wait_done(n);
        grid_in = {8{8'hAA}}; grid_valid = 1;
        @(negedge clk); grid_valid = 0;
        check("t4_ack_a", 64'(frame_ack), 64'h1);
        @(negedge clk);
        check("t4_ack_gap", 64'(frame_ack), 64'h0);
        grid_in = {8{8'h55}}; grid_valid = 1;
        @(negedge clk); grid_valid = 0;
        check("t4_ack_b", 64'(frame_ack), 64'h1);
        wait_done(n);
        for (int r = 0; r < 8; r++) begin
            wait_row(r, ok);
            check("t4_rows", 64'(col_data), 64'h55);
        end

        // 5: disable during row 3 dwell
        wait_row(3, ok);
        enable = 0;
        cnt = 1;
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (row_sel == 8'h08) cnt++;
            if (frame_done) n++;
        end
        check("t5_row3_cycles", 64'(cnt), 64'(DW));
        check("t5_no_done", 64'(n), 64'h0);
        check("t5_dark", 64'(row_sel), 64'h0);
        enable = 1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (row_sel != 0) begin
                n = i;
                break;
            end
        end
        check("t5_restart_lat", 64'(n), 64'(BL + 2));
        check("t5_restart_row", 64'(row_sel), 64'h01);

        // 6: reset during row 5 clears outputs and buffers
        wait_row(5, ok);
        reset = 1; enable = 0;
        @(negedge clk);
        check("t6_rst_row", 64'(row_sel), 64'h0);
        check("t6_rst_col", 64'(col_data), 64'h0);
        reset = 0;
        @(negedge clk);
        enable = 1;
        for (int r = 0; r < 8; r++) begin
            wait_row(r, ok);
            check("t6_cleared", 64'(col_data), 64'h0);
        end

        // Table: load while idle, then check one row's slice
        foreach (vt[i]) begin
            enable = 0;
            repeat (12) @(negedge clk);
            grid_in = vt[i].grid; grid_valid = 1;
            @(negedge clk);
            grid_valid = 0; enable = 1;
            wait_row(vt[i].row, ok);
            check("tbl_col", 64'(col_data), 64'(vt[i].col));
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            grid_valid = ($urandom_range(7) == 0);
            grid_in    = {$urandom, $urandom};
            if ($urandom_range(39) == 0) enable = ~enable;
            reset = ($urandom_range(299) == 0);
        end
        reset = 0; grid_valid = 0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
